// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants and grant encoding for the regfile write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam logic [4:0]  REG_XZR   = 5'd31;
    localparam int unsigned N_DEFAULT = 64;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_PIPE  = 2'd1,
        GNT_AUX   = 2'd2,
        GNT_STALL = 2'd3
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/aux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aux_fifo
// Brief    : Two-entry in-order queue of {wa,wd} aux writes with pending bitmap.
// Revision : 1.0 - initial release
// ============================================================================
module aux_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [4:0]   i_wa,
    input  logic [N-1:0] i_wd,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [4:0]   o_head_wa,
    output logic [N-1:0] o_head_wd,
    output logic [31:0]  o_pending
);

    logic [4:0]   r_wa [2];
    logic [N-1:0] r_wd [2];
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_wr_ptr;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_head_wa = r_wa[r_rd_ptr];
    assign o_head_wd = r_wd[r_rd_ptr];

    // Next free slot sits right behind the head; pushes into a full queue never arrive.
    assign w_wr_ptr  = r_rd_ptr ^ r_count[0];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_wa[w_wr_ptr] <= i_wa;
            r_wd[w_wr_ptr] <= i_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_pending = '0;
        if (!o_empty) begin
            o_pending[r_wa[r_rd_ptr]] = 1'b1;
        end
        if (o_full) begin
            o_pending[r_wa[~r_rd_ptr]] = 1'b1;
        end
        o_pending[REG_XZR] = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/regwrite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regwrite_arbiter
// Brief    : Shares one regfile write port between pipeline writeback and a
//            queued multi-cycle unit, stalling the pipe when aux writes starve.
// Revision : 1.0 - initial release
// ============================================================================
module regwrite_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N            = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pipe_we,
    input  logic [4:0]   pipe_wa,
    input  logic [N-1:0] pipe_wd,
    input  logic         aux_valid,
    output logic         aux_ready,
    input  logic [4:0]   aux_wa,
    input  logic [N-1:0] aux_wd,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [N-1:0] wd3,
    output logic         pipe_stall,
    output logic [31:0]  aux_pending
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;
    grant_t        w_grant;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_req;
    logic [4:0]    w_head_wa;
    logic [N-1:0]  w_head_wd;

    assign aux_ready  = !w_full && !reset;
    // XZR aux writes are handshaken but simply dropped.
    assign w_push     = aux_valid && aux_ready && (aux_wa != REG_XZR);
    assign w_pipe_req = pipe_we && (pipe_wa != REG_XZR);

    aux_fifo #(
        .N (N)
    ) u_aux_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_push),
        .i_wa      (aux_wa),
        .i_wd      (aux_wd),
        .i_pop     (w_pop),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head_wa (w_head_wa),
        .o_head_wd (w_head_wd),
        .o_pending (aux_pending)
    );

    always_comb begin
        w_grant = GNT_NONE;
        if (reset) begin
            w_grant = GNT_NONE;
        end else if (!w_empty && (r_starve_cnt == C_LIMIT)) begin
            w_grant = GNT_STALL;
        end else if (w_pipe_req) begin
            w_grant = GNT_PIPE;
        end else if (!w_empty) begin
            w_grant = GNT_AUX;
        end
    end

    assign w_pop = (w_grant == GNT_AUX) || (w_grant == GNT_STALL);

    always_comb begin
        we3        = 1'b0;
        wa3        = '0;
        wd3        = '0;
        pipe_stall = 1'b0;
        case (w_grant)
            GNT_PIPE: begin
                we3 = 1'b1;
                wa3 = pipe_wa;
                wd3 = pipe_wd;
            end
            GNT_AUX: begin
                we3 = 1'b1;
                wa3 = w_head_wa;
                wd3 = w_head_wd;
            end
            GNT_STALL: begin
                we3        = 1'b1;
                wa3        = w_head_wa;
                wd3        = w_head_wd;
                pipe_stall = 1'b1;
            end
            default: begin
                we3 = 1'b0;
            end
        endcase
    end

    // Counts pipe wins over a waiting aux entry; any retirement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_pop) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GNT_PIPE) && !w_empty && (r_starve_cnt != C_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameters SHALL be: N, 64, data width of the register file write port.
REQ-002 Parameters SHALL also include: STARVE_LIMIT, 4, the number of consecutive cycles a queued aux write may be denied before the pipeline is stalled.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- pipe_we  in  1  pipeline writeback request
- pipe_wa  in  5  pipeline destination register
- pipe_wd  in  N  pipeline write data
- aux_valid  in  1  multi-cycle unit write offer
- aux_ready  out  1  arbiter accepts the aux offer
- aux_wa  in  5  aux destination register
- aux_wd  in  N  aux write data
- we3  out  1  regfile write enable
- wa3  out  5  regfile write address
- wd3  out  N  regfile write data
- pipe_stall  out  1  pipeline must hold its writeback this cycle
- aux_pending  out  32  bitmap of registers with queued aux writes

Function
REQ-004 The block SHALL queue aux writes in a 2-entry in-order FIFO; an aux write SHALL transfer on a posedge where aux_valid && aux_ready.
REQ-005 aux_ready SHALL be !full && !reset, registered-state based only, and SHALL NOT depend on a same-cycle pop (no push to a full FIFO).
REQ-006 An aux write to register 31 (XZR) SHALL be accepted and SHALL NOT be enqueued; a pipe write to register 31 SHALL NOT be treated as a request.
REQ-007 The grant SHALL be combinational each cycle:
- STALL grant when the FIFO is non-empty and starve_cnt == STARVE_LIMIT.
- else PIPE grant when pipe_we && pipe_wa != 31.
- else AUX grant when the FIFO is non-empty.
- else no grant.
REQ-008 Under PIPE grant, we3=1, wa3=pipe_wa, wd3=pipe_wd, and the FIFO SHALL be unchanged.
REQ-009 Under AUX or STALL grant, we3=1, wa3/wd3 SHALL equal the FIFO head, and the head SHALL pop at the posedge.
REQ-010 pipe_stall SHALL be 1 exactly in STALL-grant cycles; the pipeline holds and re-presents its write the next cycle.
REQ-011 With no grant, we3 SHALL be 0, and wa3/wd3 SHALL be 0.
REQ-012 starve_cnt (0..STARVE_LIMIT) SHALL behave as follows:
- increment when the FIFO is non-empty and the grant is PIPE;
- clear on any pop;
- hold otherwise;
- never exceed STARVE_LIMIT.
REQ-013 Simultaneous push and pop SHALL be legal when not full; occupancy is unchanged, and a push into an empty FIFO SHALL NOT be granted in the same cycle (one-cycle minimum aux latency).
REQ-014 aux_pending[r] SHALL be 1 while any FIFO entry targets r; it SHALL reflect registered FIFO contents only, and bit 31 SHALL always be 0.
REQ-015 Two queued entries with the same wa SHALL retire oldest-first; the last write wins.

Reset
REQ-016 While reset is high at a posedge, the FIFO SHALL empty, starve_cnt SHALL be 0, and any in-flight aux entries SHALL be discarded.
REQ-017 During and after reset, until the next push, the outputs SHALL be: aux_ready=0 during reset, we3=0, pipe_stall=0, aux_pending=0.
REQ-018 Reset asserted mid-stall SHALL drop the stall the cycle after the reset edge, with no write issued from the discarded entry.

Structure
REQ-019 Package regfile_pkg SHALL hold REG_XZR=5'd31, the default N, and the grant enum {GNT_NONE, GNT_PIPE, GNT_AUX, GNT_STALL}.
REQ-020 The FIFO SHALL be one sub-module, aux_fifo (2-entry, {wa,wd} payload, full/empty/head outputs, pending bitmap output); the arbitration and counter logic SHALL reside in regwrite_arbiter.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Aux X10=0xAA offered on an idle pipe: accepted at cycle 0; at cycle 1, we3=1, wa3=10, wd3=0xAA; aux_pending[10] is 1 for exactly one cycle.
- pipe_we=1 X5 every cycle, with aux X7 queued: PIPE grant for 4 cycles; on the 5th cycle, pipe_stall=1, wa3=7; on the 6th cycle, wa3=5.
- Three back-to-back aux offers with the pipe busy: aux_ready drops after 2 accepts; the 3rd is accepted only after the first pop.
- Aux write to X31 and pipe write to X31: aux_ready=1, nothing enqueued, we3=0, aux_pending=0.
- Aux X3=1 then X3=2 queued: retire in order; a regfile readback of X3 returns 2.
- Reset asserted while starve_cnt=4 and the FIFO is full: the cycle after, FIFO empty, pipe_stall=0, we3=0, aux_ready=0 during reset.
